a_rom_reader: RTL and testbench



---
 rtl/a_rom_reader.sv | 152 +++++++++++++++
 tb/tb_a_rom_reader.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a_rom_reader.sv
// Read sequencer for the packed A-matrix ROM: walks 16 words, unpacks two elements each.
// Optional per-column sum outputs are enabled with A_READER_COLSUM_EN.
module a_rom_reader #(
    parameter int DATA_W = 7,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [2*DATA_W-1:0] A_input,
    output logic [DATA_W-1:0]   out_data,
    output logic [2:0]          out_row,
    output logic [1:0]          out_col,
    output logic                out_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done
`ifdef A_READER_COLSUM_EN
    ,
    output logic [DATA_W+2:0]   col_sum,
    output logic                col_sum_valid
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_CAPT, S_EMIT_HI, S_EMIT_LO, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] K_LAST = '1;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   k, k_n;
    logic [2*DATA_W-1:0] word_q;
    logic                word_ld;

    // The word counter doubles as the registered ROM address.
    assign rom_addr = k;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            k      <= '0;
            word_q <= '0;
        end else begin
            state <= state_n;
            k     <= k_n;
            if (word_ld) word_q <= A_input;
        end
    end

    always_comb begin
        state_n   = state;
        k_n       = k;
        word_ld   = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_row   = '0;
        out_col   = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_REQ;
                    k_n     = '0;
                end
            end
            S_REQ: begin
                busy    = 1'b1;
                state_n = S_CAPT;
            end
            S_CAPT: begin
                busy    = 1'b1;
                word_ld = 1'b1;
                state_n = S_EMIT_HI;
            end
            S_EMIT_HI: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = word_q[2*DATA_W-1:DATA_W];
                out_row   = {k[1:0], 1'b0};
                out_col   = k[ADDR_W-1 -: 2];
                if (out_ready) state_n = S_EMIT_LO;
            end
            S_EMIT_LO: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = word_q[DATA_W-1:0];
                out_row   = {k[1:0], 1'b1};
                out_col   = k[ADDR_W-1 -: 2];
                out_last  = (k == K_LAST);
                if (out_ready) begin
                    if (k == K_LAST) begin
                        state_n = S_DONE;
                        k_n     = '0;
                    end else begin
                        state_n = S_REQ;
                        k_n     = k + 1'b1;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (abort) begin
            state_n = S_IDLE;
            k_n     = '0;
            word_ld = 1'b0;
        end
    end

`ifdef A_READER_COLSUM_EN
    logic [DATA_W+2:0] acc;
    logic [DATA_W+2:0] sum_n;
    logic              col_end;

    assign sum_n   = acc + {3'b000, out_data};
    assign col_end = (state == S_EMIT_LO) && (k[1:0] == 2'b11);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc           <= '0;
            col_sum       <= '0;
            col_sum_valid <= 1'b0;
        end else begin
            col_sum_valid <= 1'b0;
            if (abort) begin
                acc     <= '0;
                col_sum <= '0;
            end else if (state == S_IDLE && start) begin
                acc <= '0;
            end else if (out_valid && out_ready) begin
                if (col_end) begin
                    col_sum       <= sum_n;
                    col_sum_valid <= 1'b1;
                    acc           <= '0;
                end else begin
                    acc <= sum_n;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_a_rom_reader.sv
// Scoreboard bench for a_rom_reader with a registered-read ROM model.
// Column-sum checks are active when A_READER_COLSUM_EN is defined.
module tb_a_rom_reader;
    localparam int DW = 7;
    localparam int AW = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [2:0]    r;
        logic [1:0]    c;
        logic          l;
    } elem_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [2*DW-1:0] a_input = '0;
    logic [DW-1:0] out_data;
    logic [2:0]    out_row;
    logic [1:0]    out_col;
    logic          out_last;
    logic          out_valid;
    logic          busy;
    logic          done;
`ifdef A_READER_COLSUM_EN
    logic [DW+2:0] col_sum;
    logic          col_sum_valid;
`endif

    a_rom_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .rom_addr(rom_addr),
        .A_input(a_input),
        .out_data(out_data),
        .out_row(out_row),
        .out_col(out_col),
        .out_last(out_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .done(done)
`ifdef A_READER_COLSUM_EN
        ,
        .col_sum(col_sum),
        .col_sum_valid(col_sum_valid)
`endif
    );

    always #5 clk = ~clk;

    logic [2*DW-1:0] rom [16];
    always @(posedge clk) a_input <= rom[rom_addr];

    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;
    elem_t sb[$];
    int    cs_q[$];

    function automatic logic [DW-1:0] mat(input int r, input int c);
        return (c == 0) ? DW'(r + 1) : DW'(1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_all();
        int sum;
        elem_t e;
        sb.delete();
        cs_q.delete();
        for (int c = 0; c < 4; c++) begin
            sum = 0;
            for (int r = 0; r < 8; r++) begin
                e.d = mat(r, c);
                e.r = 3'(r);
                e.c = 2'(c);
                e.l = (r == 7) && (c == 3);
                sb.push_back(e);
                sum += int'(mat(r, c));
            end
            cs_q.push_back(sum);
        end
    endtask

    task automatic stream(input int stall_idx, input int stall_len,
                          input int restart_idx);
        int    idx = 0;
        int    stall = 0;
        int    dones = 0;
        int    t0;
        int    pend = -1;
        int    pulses = 0;
        bit    first = 1'b1;
        elem_t e, held, cur;
        push_all();
        out_ready = 1'b1;
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        for (int i = 0; i < 300 && dones == 0; i++) begin
            start = 1'b0;
            cur = {out_data, out_row, out_col, out_last};
`ifdef A_READER_COLSUM_EN
            if (col_sum_valid) begin
                n_chk++;
                pulses++;
                if (cs_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL col_sum_extra: got %0d at cyc %0d", col_sum, cyc);
                end else begin
                    if (cyc != pend || int'(col_sum) != cs_q[0]) begin
                        n_fail++;
                        $display("FAIL col_sum: got %0d@%0d want %0d@%0d",
                                 col_sum, cyc, cs_q[0], pend);
                    end
                    void'(cs_q.pop_front());
                end
            end
`endif
            if (out_valid) begin
                if (first) begin
                    n_chk++;
                    if (cyc != t0 + 3) begin
                        n_fail++;
                        $display("FAIL first_valid: got T+%0d want T+3", cyc - t0);
                    end
                    first = 1'b0;
                end
                if (idx == restart_idx) start = 1'b1;
                if (idx == stall_idx && stall < stall_len) begin
                    if (stall == 0) held = cur;
                    else begin
                        n_chk++;
                        if (cur !== held) begin
                            n_fail++;
                            $display("FAIL stall_hold: got %h want %h", cur, held);
                        end
                    end
                    out_ready = 1'b0;
                    stall++;
                end else begin
                    out_ready = 1'b1;
                    n_chk++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_elem: got %h want none", cur);
                    end else begin
                        e = sb.pop_front();
                        if (cur !== e) begin
                            n_fail++;
                            $display("FAIL elem%0d: got %h want %h", idx, cur, e);
                        end
                    end
                    if (out_row == 3'd7) pend = cyc + 1;
                    idx++;
                end
            end
            if (done) begin
                dones++;
                n_chk++;
                if (cyc != t0 + 65 + stall_len || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_time: got T+%0d busy %0b want T+%0d busy 0",
                             cyc - t0, busy, 65 + stall_len);
                end
            end
            tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
        n_chk++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL done_seen: got %0d want 1", dones);
        end
        n_chk++;
        if (idx != 32 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL elem_count: got %0d left %0d want 32 left 0", idx, sb.size());
        end
        for (int i = 0; i < 4; i++) begin
`ifdef A_READER_COLSUM_EN
            if (col_sum_valid) pulses++;
`endif
            n_chk++;
            if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL after_done: got done %0b valid %0b busy %0b want 0",
                         done, out_valid, busy);
            end
            tick();
        end
`ifdef A_READER_COLSUM_EN
        n_chk++;
        if (pulses != 4) begin
            n_fail++;
            $display("FAIL col_pulses: got %0d want 4", pulses);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_chk++;
        if (rom_addr !== '0 || out_data !== '0 || out_row !== '0 ||
            out_col !== '0 || out_last !== 1'b0 || out_valid !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got addr %0d data %0d valid %0b busy %0b want 0",
                     rom_addr, out_data, out_valid, busy);
        end
`ifdef A_READER_COLSUM_EN
        n_chk++;
        if (col_sum !== '0 || col_sum_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_colsum: got %0d/%0b want 0/0", col_sum, col_sum_valid);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full();
        stream(-1, 0, -1);
    endtask

    task automatic test_stall();
        stream(3, 5, -1);
    endtask

    task automatic test_start_busy();
        stream(-1, 0, 10);
    endtask

    task automatic test_abort_idle();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_idle: got busy %0b want 0", busy);
            end
            tick();
        end
    endtask

    task automatic test_abort();
        int    idx = 0;
        bit    hit = 1'b0;
        elem_t e, cur;
        push_all();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (out_valid) begin
                cur = {out_data, out_row, out_col, out_last};
                if (idx == 10) begin
                    out_ready = 1'b0;
                    abort = 1'b1;
                    hit = 1'b1;
                end else begin
                    e = sb.pop_front();
                    n_chk++;
                    if (cur !== e) begin
                        n_fail++;
                        $display("FAIL abort_pre%0d: got %h want %h", idx, cur, e);
                    end
                    idx++;
                end
            end
            tick();
        end
        abort = 1'b0;
        out_ready = 1'b1;
        n_chk++;
        if (!hit || out_valid !== 1'b0 || rom_addr !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: got hit %0b valid %0b addr %0d busy %0b want 1 0 0 0",
                     hit, out_valid, rom_addr, busy);
        end
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (done !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_nodone: got done %0b valid %0b want 0", done, out_valid);
            end
            tick();
        end
        stream(-1, 0, -1);
    endtask

    task automatic test_reset_mid();
        int t0;
        out_ready = 1'b1;
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        while (cyc < t0 + 22) tick();
        n_chk++;
        if (rom_addr !== 4'd5 || busy !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL capt5: got addr %0d busy %0b valid %0b want 5 1 0",
                     rom_addr, busy, out_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if (rom_addr !== '0 || out_data !== '0 || out_row !== '0 ||
            out_col !== '0 || out_last !== 1'b0 || out_valid !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got addr %0d data %0d valid %0b busy %0b want 0",
                     rom_addr, out_data, out_valid, busy);
        end
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_nodone: got done %0b busy %0b want 0", done, busy);
            end
            tick();
        end
        stream(-1, 0, -1);
    endtask

    initial begin
        for (int k = 0; k < 16; k++)
            rom[k] = {mat(2 * (k % 4), k / 4), mat(2 * (k % 4) + 1, k / 4)};
        test_reset();
        test_full();
        test_stall();
        test_start_busy();
        test_abort_idle();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
